// File: rtl/serial_max_frame_ctrl_if.sv
// Sample-stream and frame-result handshake bundle for serial_max_frame_ctrl.
// The producer/consumer side uses master; the controller uses slave.
interface serial_max_frame_ctrl_if #(
    parameter int WIDTH     = 4,
    parameter int IDX_WIDTH = 3
);
    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     in_data;
    logic                 in_last;
    logic                 out_valid;
    logic                 out_ready;
    logic [WIDTH-1:0]     out_max;
    logic [IDX_WIDTH-1:0] out_index;
    logic [IDX_WIDTH:0]   out_count;
    logic                 out_forced;

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_max, out_index, out_count, out_forced
    );

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_max, out_index, out_count, out_forced
    );
endinterface

// File: rtl/serial_max_frame_ctrl.sv
// Frame controller for a signed running-maximum datapath over a valid/ready
// sample stream; reports max, first index of max, count and forced-close flag.
//
//   state | meaning
//   IDLE  | waiting for the first sample of a frame
//   ACCUM | frame open, folding samples into the running max
//   HOLD  | result presented on the out port, input stalled
module serial_max_frame_ctrl #(
    parameter int WIDTH     = 4,
    parameter int IDX_WIDTH = 3,
    parameter int MAX_LEN   = 8
) (
    input logic               clk,
    input logic               rst,
    input logic               clear,
    serial_max_frame_ctrl_if.slave bus
);
    localparam logic signed [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [IDX_WIDTH:0]      LEN_LIM = (IDX_WIDTH+1)'(MAX_LEN);
    localparam logic [IDX_WIDTH:0]      CNT_ONE = (IDX_WIDTH+1)'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t                  state, state_nxt;
    logic signed [WIDTH-1:0] run_max, run_max_nxt;
    logic [IDX_WIDTH-1:0]    run_idx, run_idx_nxt;
    logic [IDX_WIDTH:0]      run_cnt, run_cnt_nxt;

    logic signed [WIDTH-1:0] res_max, res_max_nxt;
    logic [IDX_WIDTH-1:0]    res_idx, res_idx_nxt;
    logic [IDX_WIDTH:0]      res_cnt, res_cnt_nxt;
    logic                    res_forced, res_forced_nxt;

    logic                    in_ready_int;
    logic                    accept;
    logic                    close;
    logic                    close_forced;
    logic [IDX_WIDTH:0]      cnt_inc;
    logic signed [WIDTH-1:0] sample;

    assign in_ready_int = !rst && (state != HOLD);
    assign accept       = bus.in_valid && in_ready_int;
    assign cnt_inc      = run_cnt + CNT_ONE;
    assign sample       = $signed(bus.in_data);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            run_max    <= MIN_VAL;
            run_idx    <= '0;
            run_cnt    <= '0;
            res_max    <= MIN_VAL;
            res_idx    <= '0;
            res_cnt    <= '0;
            res_forced <= 1'b0;
        end else begin
            state      <= state_nxt;
            run_max    <= run_max_nxt;
            run_idx    <= run_idx_nxt;
            run_cnt    <= run_cnt_nxt;
            res_max    <= res_max_nxt;
            res_idx    <= res_idx_nxt;
            res_cnt    <= res_cnt_nxt;
            res_forced <= res_forced_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        run_max_nxt    = run_max;
        run_idx_nxt    = run_idx;
        run_cnt_nxt    = run_cnt;
        res_max_nxt    = res_max;
        res_idx_nxt    = res_idx;
        res_cnt_nxt    = res_cnt;
        res_forced_nxt = res_forced;
        close          = 1'b0;
        close_forced   = 1'b0;

        case (state)
            IDLE: begin
                if (accept) begin
                    run_max_nxt = sample;
                    run_idx_nxt = '0;
                    run_cnt_nxt = CNT_ONE;
                    if (bus.in_last || MAX_LEN == 1) begin
                        close        = 1'b1;
                        close_forced = !bus.in_last;
                    end else begin
                        state_nxt = ACCUM;
                    end
                end
            end
            ACCUM: begin
                if (accept) begin
                    // strict compare so ties keep the earlier index
                    if (sample > run_max) begin
                        run_max_nxt = sample;
                        run_idx_nxt = run_cnt[IDX_WIDTH-1:0];
                    end
                    run_cnt_nxt = cnt_inc;
                    if (bus.in_last || cnt_inc == LEN_LIM) begin
                        close        = 1'b1;
                        close_forced = !bus.in_last;
                    end
                end
            end
            HOLD: begin
                if (bus.out_ready) begin
                    state_nxt   = IDLE;
                    run_max_nxt = MIN_VAL;
                    run_idx_nxt = '0;
                    run_cnt_nxt = '0;
                end
            end
            default: begin
                state_nxt   = IDLE;
                run_max_nxt = MIN_VAL;
                run_idx_nxt = '0;
                run_cnt_nxt = '0;
            end
        endcase

        if (close) begin
            state_nxt      = HOLD;
            res_max_nxt    = run_max_nxt;
            res_idx_nxt    = run_idx_nxt;
            res_cnt_nxt    = run_cnt_nxt;
            res_forced_nxt = close_forced;
        end

        // abort wins over any transfer in the same cycle; result data is kept
        if (clear) begin
            state_nxt      = IDLE;
            run_max_nxt    = MIN_VAL;
            run_idx_nxt    = '0;
            run_cnt_nxt    = '0;
            res_max_nxt    = res_max;
            res_idx_nxt    = res_idx;
            res_cnt_nxt    = res_cnt;
            res_forced_nxt = res_forced;
        end
    end

    assign bus.in_ready   = in_ready_int;
    assign bus.out_valid  = (state == HOLD);
    assign bus.out_max    = res_max;
    assign bus.out_index  = res_idx;
    assign bus.out_count  = res_cnt;
    assign bus.out_forced = res_forced;
endmodule

// File: tb/tb_serial_max_frame_ctrl.sv
// Bench for serial_max_frame_ctrl: directed frames plus random frames checked
// against a reference computed from the frame rules over a sample queue.
module tb_serial_max_frame_ctrl;
    localparam int WIDTH     = 4;
    localparam int IDX_WIDTH = 3;
    localparam int MAX_LEN   = 8;

    logic clk;
    logic rst;
    logic clear;
    int   n_tests = 0;
    int   n_fail  = 0;

    serial_max_frame_ctrl_if #(.WIDTH(WIDTH), .IDX_WIDTH(IDX_WIDTH)) ifc ();

    serial_max_frame_ctrl #(
        .WIDTH(WIDTH), .IDX_WIDTH(IDX_WIDTH), .MAX_LEN(MAX_LEN)
    ) dut (
        .clk(clk),
        .rst(rst),
        .clear(clear),
        .bus(ifc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input int obs, input int exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Expected result: max over the frame, first position holding it, length,
    // and forced when the length limit rather than in_last ended the frame.
    task automatic ref_model(input int s[$], input bit last,
                             output int mx, output int idx, output int cnt,
                             output int forced);
        mx  = s[0];
        idx = 0;
        foreach (s[i]) if (s[i] > mx) begin mx = s[i]; idx = i; end
        cnt    = s.size();
        forced = (cnt == MAX_LEN && !last) ? 1 : 0;
    endtask

    task automatic send(input int d, input bit last);
        int k = 0;
        ifc.in_valid = 1'b1;
        ifc.in_data  = WIDTH'(d);
        ifc.in_last  = last;
        while (!ifc.in_ready && k < 20) begin tick(); k++; end
        check("in_ready_wait", int'(ifc.in_ready), 1);
        tick();
        ifc.in_valid = 1'b0;
        ifc.in_last  = 1'b0;
    endtask

    task automatic check_result(input string tag, input int mx, input int idx,
                                input int cnt, input int forced);
        check({tag, "_valid"},  int'(ifc.out_valid), 1);
        check({tag, "_max"},    int'($signed(ifc.out_max)), mx);
        check({tag, "_index"},  int'(ifc.out_index), idx);
        check({tag, "_count"},  int'(ifc.out_count), cnt);
        check({tag, "_forced"}, int'(ifc.out_forced), forced);
    endtask

    task automatic collect(input int bp, input int mx, input int idx,
                           input int cnt, input int forced);
        ifc.out_ready = 1'b0;
        for (int i = 0; i < bp; i++) begin
            tick();
            check("bp_in_ready", int'(ifc.in_ready), 0);
            check_result("bp", mx, idx, cnt, forced);
        end
        ifc.out_ready = 1'b1;
        tick();
        ifc.out_ready = 1'b0;
        check("taken_valid", int'(ifc.out_valid), 0);
        check("taken_in_ready", int'(ifc.in_ready), 1);
    endtask

    task automatic run_frame(input string tag, input int s[$], input bit last,
                             input int gap_pct, input int bp);
        int mx, idx, cnt, forced;
        ref_model(s, last, mx, idx, cnt, forced);
        for (int i = 0; i < s.size(); i++) begin
            if ($urandom_range(99, 0) < gap_pct) begin
                repeat ($urandom_range(2, 1)) begin
                    ifc.in_valid  = 1'b0;
                    ifc.in_last   = 1'($urandom_range(1, 0));
                    ifc.in_data   = WIDTH'($urandom);
                    ifc.out_ready = 1'($urandom_range(1, 0));
                    tick();
                    check({tag, "_gap_valid"}, int'(ifc.out_valid), 0);
                end
                ifc.in_last   = 1'b0;
                ifc.out_ready = 1'b0;
            end
            check({tag, "_open_valid"}, int'(ifc.out_valid), 0);
            send(s[i], last && (i == s.size() - 1));
        end
        check_result(tag, mx, idx, cnt, forced);
        collect(bp, mx, idx, cnt, forced);
    endtask

    initial begin
        int s[$];
        rst           = 1'b1;
        clear         = 1'b0;
        ifc.in_valid  = 1'b0;
        ifc.in_data   = '0;
        ifc.in_last   = 1'b0;
        ifc.out_ready = 1'b0;
        tick();
        ifc.in_valid = 1'b1;
        #1;
        check("rst_in_ready",  int'(ifc.in_ready), 0);
        check("rst_out_valid", int'(ifc.out_valid), 0);
        check("rst_out_max",   int'($signed(ifc.out_max)), -8);
        check("rst_out_index", int'(ifc.out_index), 0);
        check("rst_out_count", int'(ifc.out_count), 0);
        check("rst_forced",    int'(ifc.out_forced), 0);
        tick();
        check("rst_hold_valid", int'(ifc.out_valid), 0);
        ifc.in_valid = 1'b0;
        rst = 1'b0;
        tick();
        check("idle_in_ready", int'(ifc.in_ready), 1);

        // ascending frame, back-pressure of 4 cycles
        s = {};
        for (int v = -8; v <= -1; v++) s.push_back(v);
        run_frame("ascend", s, 1'b1, 0, 4);

        s = {-3, 5, 2, 5, -8};
        run_frame("tie", s, 1'b1, 0, 0);

        s = {-8};
        run_frame("single_min", s, 1'b1, 0, 1);

        s = {-8, -8, -8};
        run_frame("all_min", s, 1'b1, 30, 0);

        // forced close; 9th sample must wait for the result to be taken
        for (int i = 0; i < 8; i++) send(3, 1'b0);
        check_result("forced", 3, 0, 8, 1);
        ifc.in_valid = 1'b1;
        ifc.in_data  = WIDTH'(5);
        ifc.in_last  = 1'b1;
        tick();
        tick();
        check("forced_9th_ready", int'(ifc.in_ready), 0);
        check_result("forced_hold", 3, 0, 8, 1);
        ifc.out_ready = 1'b1;
        tick();
        ifc.out_ready = 1'b0;
        check("forced_taken_valid", int'(ifc.out_valid), 0);
        tick();
        ifc.in_valid = 1'b0;
        ifc.in_last  = 1'b0;
        check_result("ninth", 5, 0, 1, 0);
        collect(0, 5, 0, 1, 0);

        // clear after 3 samples, with a discarded transfer in the same cycle
        send(6, 1'b0);
        send(2, 1'b0);
        send(6, 1'b0);
        clear        = 1'b1;
        ifc.in_valid = 1'b1;
        ifc.in_data  = WIDTH'(7);
        ifc.in_last  = 1'b1;
        tick();
        clear        = 1'b0;
        ifc.in_valid = 1'b0;
        ifc.in_last  = 1'b0;
        check("clear_valid", int'(ifc.out_valid), 0);
        check("clear_in_ready", int'(ifc.in_ready), 1);
        tick();
        check("clear_valid2", int'(ifc.out_valid), 0);
        s = {-5};
        run_frame("after_clear", s, 1'b1, 0, 0);

        // clear while a result is pending drops it
        send(4, 1'b1);
        check_result("pre_clear_hold", 4, 0, 1, 0);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("clear_hold_valid", int'(ifc.out_valid), 0);
        check("clear_hold_ready", int'(ifc.in_ready), 1);

        // reset mid-frame
        send(4, 1'b0);
        send(4, 1'b0);
        rst = 1'b1;
        #1;
        check("rst_mid_ready", int'(ifc.in_ready), 0);
        check("rst_mid_max", int'($signed(ifc.out_max)), -8);
        tick();
        rst = 1'b0;
        tick();
        check("rst_mid_valid", int'(ifc.out_valid), 0);

        // reset while holding a result
        send(1, 1'b0);
        send(2, 1'b1);
        check_result("pre_rst_hold", 2, 1, 2, 0);
        rst = 1'b1;
        #1;
        check("rst_hold_drop", int'(ifc.out_valid), 0);
        tick();
        rst = 1'b0;
        tick();
        check("rst_hold_after", int'(ifc.out_valid), 0);
        s = {7};
        run_frame("seven", s, 1'b1, 0, 0);

        // random frames
        for (int f = 0; f < 24; f++) begin
            int len;
            bit last;
            len = $urandom_range(MAX_LEN, 1);
            s = {};
            for (int i = 0; i < len; i++) s.push_back(int'($urandom_range(15, 0)) - 8);
            last = (len < MAX_LEN) ? 1'b1 : 1'($urandom_range(1, 0));
            run_frame("rand", s, last, 25, $urandom_range(3, 0));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/serial_max_frame_ctrl.md
Name: serial_max_frame_ctrl

Overview:
- Frame-level controller that sequences a signed running-maximum datapath over a valid/ready sample stream.
- Each frame starts on the first accepted sample and ends on `in_last` or after `MAX_LEN` samples.
- Per frame it reports the maximum, the index of its first occurrence and the sample count, on a valid/ready result port.
- Sits between a sample producer (ADC/feature stream) and downstream peak-detect logic.

Parameters:
- WIDTH, 4, sample width in bits, signed two's complement.
- IDX_WIDTH, 3, width of the sample index; the index ranges 0..MAX_LEN-1.
- MAX_LEN, 8, maximum samples per frame; must satisfy MAX_LEN <= 2**IDX_WIDTH and MAX_LEN >= 1.

Ports:
- clk  input  1  system clock, all state changes on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- clear  input  1  synchronous abort: drops any partial frame and any pending result.
- in_valid  input  1  sample valid.
- in_ready  output  1  controller accepts a sample this cycle.
- in_data  input  WIDTH  signed sample.
- in_last  input  1  marks the final sample of the frame; qualified by in_valid.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts the result.
- out_max  output  WIDTH  signed frame maximum.
- out_index  output  IDX_WIDTH  index of the first sample equal to out_max.
- out_count  output  IDX_WIDTH+1  number of samples in the frame (1..MAX_LEN).
- out_forced  output  1  frame closed by the MAX_LEN limit, not by in_last.

Behaviour:
- Reset (asynchronous, immediate):
  - state = IDLE, out_valid = 0.
  - out_max = -2**(WIDTH-1).
  - out_index = 0, out_count = 0, out_forced = 0.
  - Internal running max = -2**(WIDTH-1), internal count = 0.
  - in_ready = 0 while rst is high.
- Handshakes:
  - Input transfer occurs when in_valid && in_ready on a rising edge.
  - Output transfer occurs when out_valid && out_ready on a rising edge.
  - in_ready = !rst && (state != HOLD). in_ready does not depend combinationally on in_valid.
- IDLE:
  - On an input transfer, load the running max with in_data, set the running index to 0 and the count to 1.
  - If in_last is set or MAX_LEN == 1, go to HOLD. Otherwise go to ACCUM.
- ACCUM:
  - On each input transfer, compare using signed arithmetic only.
  - Replace the max and index only if in_data > current max (strict). Ties keep the earlier index.
  - Count increments by 1 per transfer.
  - The frame closes when in_last is set, or when this transfer brings the count to MAX_LEN; the latter is a forced close with out_forced = 1 even if in_last = 0.
  - On close, go to HOLD.
  - No transfer: hold all state.
- HOLD:
  - Output registers are loaded on the closing edge, so out_valid = 1 in the cycle immediately after the last sample transfer (latency 1).
  - out_max, out_index, out_count and out_forced stay stable while out_valid && !out_ready.
  - On an output transfer: go to IDLE, out_valid = 0, reset the running max to the minimum. Output data registers keep their last values.
  - in_ready = 0 in HOLD, so frames never overlap.
  - Throughput is N+1 cycles per N-sample frame with no stalls.
- clear (synchronous, beats everything except rst):
  - Go to IDLE, out_valid = 0, running max = minimum, count = 0.
  - Any input transfer in the same cycle is discarded.
- Boundary cases:
  - in_last asserted with in_valid = 0 is ignored.
  - An all-minimum frame reports out_max = minimum, out_index = 0.
  - Reset mid-frame or in HOLD discards everything; no partial result is ever emitted.
  - out_ready asserted while out_valid = 0 has no effect.

Test Plan:
- All tests use WIDTH = 4, MAX_LEN = 8.
- Ascending frame: samples -8..-1, in_last on -1 → out_valid one cycle after the last transfer; out_max = -1, out_index = 7, out_count = 8, out_forced = 0.
- Tie and negative values: frame {-3, 5, 2, 5, -8} with in_last on -8 → out_max = 5, out_index = 1, out_count = 5.
- Forced close: 8 samples of value 3 with in_last never asserted → out_max = 3, out_index = 0, out_count = 8, out_forced = 1; 9th sample not accepted until the result is taken.
- Back-pressure: hold out_ready = 0 for 4 cycles after out_valid → outputs stable, in_ready = 0 throughout; out_ready = 1 → IDLE next cycle, in_ready = 1.
- Single-sample frame: in_data = -8 with in_last → out_max = -8, out_index = 0, out_count = 1.
- Abort: clear after 3 samples, then rst mid-frame and in HOLD → no out_valid pulse; a following frame {7} reports out_max = 7, out_count = 1.
